// File: rtl/judge_arbiter_pkg.sv
// Shared game package: arbiter FSM codes, judgement codes, lockout default
// and the state codes of the main game controller.
package judge_arbiter_pkg;

    // Lockout after a wrong answer: 1 s at a 50 MHz system clock.
    localparam int unsigned LOCK_CYC_DEFAULT = 50_000_000;

    // Arbiter FSM states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Judgement codes, bit p set when player p answered correctly.
    localparam logic [1:0] JUDG_NONE = 2'b00;
    localparam logic [1:0] JUDG_P0   = 2'b01;
    localparam logic [1:0] JUDG_P1   = 2'b10;
    localparam logic [1:0] JUDG_DRAW = 2'b11;

    // Main game-controller states.
    localparam logic [2:0] GAME_ST_IDLE     = 3'd0;
    localparam logic [2:0] GAME_ST_QUESTION = 3'd1;
    localparam logic [2:0] GAME_ST_ANSWER   = 3'd2;
    localparam logic [2:0] GAME_ST_SCORE    = 3'd3;
    localparam logic [2:0] GAME_ST_OVER     = 3'd4;

    // One-hot grant vector for a player index.
    function automatic logic [1:0] player_onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/judge_arbiter_lockout_timer.sv
// Per-player lockout timer: load starts a LOCK_CYC-cycle busy window,
// clr aborts it immediately.
module lockout_timer
    import judge_arbiter_pkg::*;
#(
    parameter int unsigned LOCK_CYC = LOCK_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    output logic busy
);

    localparam int unsigned CW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(LOCK_CYC - 1);

    logic [CW-1:0] count;

    // Count down from LOCK_CYC-1; busy drops in the cycle after count hits 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (load) begin
            count <= LOAD_VAL;
            busy  <= 1'b1;
        end else if (busy) begin
            if (count == '0) begin
                busy <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/judge_arbiter.sv
// Two-player answer arbiter: serialises player submissions onto one shared
// factor checker, locks out wrong answers and reports the judgement.
//
// Checker handshake: chk_start is a one-cycle launch pulse; gnt and chk_div
// are held unchanged from chk_start until the matching chk_done. chk_done
// (with chk_ok) is a one-cycle completion pulse, taken only while waiting
// for a verdict and ignored in every other state. There is no backpressure.
module judge_arbiter
    import judge_arbiter_pkg::*;
#(
    parameter int unsigned LOCK_CYC = LOCK_CYC_DEFAULT,
    parameter int unsigned W_ANS    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       req,
    input  logic [W_ANS-1:0] ans0,
    input  logic [W_ANS-1:0] ans1,
    input  logic             chk_done,
    input  logic             chk_ok,
    output logic             chk_start,
    output logic [W_ANS-1:0] chk_div,
    output logic [1:0]       gnt,
    output logic [1:0]       judg,
    output logic [1:0]       wrong,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    logic [1:0]       rst_sync;
    logic             run;
    logic             clr;
    logic [1:0]       state;
    logic [1:0]       pend;
    logic [1:0]       ok;
    logic [1:0]       ok_nx;
    logic             cur;
    logic             pair;
    logic             second;
    logic             rr;
    logic [W_ANS-1:0] ans0_q;
    logic [W_ANS-1:0] ans1_q;
    logic             owning;
    logic             done_evt;
    logic             more;
    logic             enter_done;
    logic [1:0]       accept;
    logic [1:0]       load;

    // Reset release is brought onto clk before the FSM may leave IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];
    assign clr = !run || !en;

    // Verdict merged into the per-player ok flags for the current checker owner.
    always_comb begin
        ok_nx      = ok;
        ok_nx[cur] = chk_ok;
    end

    assign owning     = (state == ST_ISSUE) || (state == ST_WAIT);
    assign done_evt   = (state == ST_WAIT) && chk_done;
    assign more       = pair && !second;
    assign enter_done = done_evt && !more && (ok_nx != 2'b00);
    assign accept     = req & ~wrong & ~pend &
                        {2{en && (state != ST_DONE) && !enter_done}};

    // Arbitration FSM with pending, verdict and judgement bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pend   <= 2'b00;
            ok     <= 2'b00;
            judg   <= JUDG_NONE;
            cur    <= 1'b0;
            pair   <= 1'b0;
            second <= 1'b0;
            rr     <= 1'b0;
        end else if (clr) begin
            state  <= ST_IDLE;
            pend   <= 2'b00;
            ok     <= 2'b00;
            judg   <= JUDG_NONE;
            cur    <= 1'b0;
            pair   <= 1'b0;
            second <= 1'b0;
        end else begin
            pend <= pend | accept;
            case (state)
                ST_IDLE: begin
                    if (pend != 2'b00) begin
                        ok     <= 2'b00;
                        second <= 1'b0;
                        state  <= ST_ISSUE;
                        if (pend == 2'b11) begin
                            cur  <= rr;
                            pair <= 1'b1;
                            rr   <= ~rr;
                        end else begin
                            cur  <= pend[1];
                            pair <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (chk_done) begin
                        pend[cur] <= 1'b0;
                        ok        <= ok_nx;
                        if (more) begin
                            cur    <= ~cur;
                            second <= 1'b1;
                            state  <= ST_ISSUE;
                        end else if (ok_nx != 2'b00) begin
                            judg  <= ok_nx;
                            state <= ST_DONE;
                        end else begin
                            judg  <= JUDG_NONE;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Answers are captured together with an accepted submission.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ans0_q <= '0;
            ans1_q <= '0;
        end else begin
            if (accept[0]) ans0_q <= ans0;
            if (accept[1]) ans1_q <= ans1;
        end
    end

    assign load = {done_evt && !chk_ok && cur, done_evt && !chk_ok && !cur};

    lockout_timer #(.LOCK_CYC(LOCK_CYC)) u_lock0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .load  (load[0]),
        .busy  (wrong[0])
    );

    lockout_timer #(.LOCK_CYC(LOCK_CYC)) u_lock1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .load  (load[1]),
        .busy  (wrong[1])
    );

    assign chk_start = (state == ST_ISSUE);
    assign gnt       = owning ? player_onehot(cur) : 2'b00;
    assign chk_div   = owning ? (cur ? ans1_q : ans0_q) : '0;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_judge_arbiter.sv
// Bench for judge_arbiter: directed cases followed by randomized rounds,
// with the bench acting as the factor checker for a fixed question.
module tb_judge_arbiter;
    import judge_arbiter_pkg::*;

    localparam int unsigned LOCK = 10;
    localparam int          W    = 8;
    localparam int          Q    = 42;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         en       = 1'b0;
    logic [1:0]   req      = 2'b00;
    logic [W-1:0] ans0     = '0;
    logic [W-1:0] ans1     = '0;
    logic         chk_done = 1'b0;
    logic         chk_ok   = 1'b0;
    logic         chk_start;
    logic [W-1:0] chk_div;
    logic [1:0]   gnt;
    logic [1:0]   judg;
    logic [1:0]   wrong;
    logic         busy;
    logic [1:0]   dbg_state;

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard: expected divisors and owners, in checker order.
    logic [W-1:0] exp_q[$];
    int           exp_p[$];
    logic         rr_m = 1'b0;
    int           abort_req[2];

    // clock / reset
    always #5 clk = ~clk;

    judge_arbiter #(.LOCK_CYC(LOCK), .W_ANS(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .ans0      (ans0),
        .ans1      (ans1),
        .chk_done  (chk_done),
        .chk_ok    (chk_ok),
        .chk_start (chk_start),
        .chk_div   (chk_div),
        .gnt       (gnt),
        .judg      (judg),
        .wrong     (wrong),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_factor(input logic [W-1:0] a);
        int v;
        v = int'(a);
        return (v > 1) && (v < Q) && ((Q % v) == 0);
    endfunction

    function automatic logic [W-1:0] pick_ans();
        case ($urandom_range(0, 7))
            0:       return 8'd2;
            1:       return 8'd3;
            2:       return 8'd6;
            3:       return 8'd7;
            4:       return 8'd14;
            5:       return 8'd21;
            default: return 8'($urandom_range(0, 63));
        endcase
    endfunction

    // Lockouts about to be cut short by EN low or reset are not length-checked.
    task automatic mark_abort();
        for (int p = 0; p < 2; p++) begin
            if (wrong[p]) abort_req[p]++;
        end
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((busy || (wrong != 2'b00)) && (n < int'(LOCK) + 40)) begin
            step();
            n++;
        end
        check("quiet", {29'd0, busy, wrong}, 32'd0);
    endtask

    // One submission round; lat_in < 0 picks a random checker latency.
    task automatic do_round(input logic [1:0] pat, input logic [W-1:0] a0, input logic [W-1:0] a1,
                            input int lat_in, input bit abort_mid);
        logic [1:0]   ok_m;
        logic [1:0]   chk_m;
        logic [W-1:0] e;
        int           p;
        int           lat;
        wait_quiet();
        ans0 = a0;
        ans1 = a1;
        req  = pat;
        if (pat == 2'b11) begin
            p    = rr_m ? 1 : 0;
            rr_m = ~rr_m;
            exp_q.push_back(p == 1 ? a1 : a0);
            exp_p.push_back(p);
            exp_q.push_back(p == 1 ? a0 : a1);
            exp_p.push_back(1 - p);
        end else begin
            p = pat[1] ? 1 : 0;
            exp_q.push_back(p == 1 ? a1 : a0);
            exp_p.push_back(p);
        end
        step();
        req  = 2'b00;
        ans0 = 8'($urandom);
        ans1 = 8'($urandom);
        check("start_early", {31'd0, chk_start}, 32'd0);
        step();
        check("start_latency", {31'd0, chk_start}, 32'd1);
        ok_m  = 2'b00;
        chk_m = 2'b00;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            p = exp_p.pop_front();
            check("issue_start", {31'd0, chk_start}, 32'd1);
            check("issue_gnt", {30'd0, gnt}, (p == 1) ? 32'd2 : 32'd1);
            check("issue_div", {24'd0, chk_div}, {24'd0, e});
            check("issue_busy", {31'd0, busy}, 32'd1);
            step();
            check("wait_start", {31'd0, chk_start}, 32'd0);
            if (abort_mid) begin
                mark_abort();
                en = 1'b0;
                step();
                en = 1'b1;
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_gnt", {30'd0, gnt}, 32'd0);
                chk_done = 1'b1;
                chk_ok   = 1'b1;
                step();
                chk_done = 1'b0;
                chk_ok   = 1'b0;
                check("late_done_judg", {30'd0, judg}, 32'd0);
                check("late_done_busy", {31'd0, busy}, 32'd0);
                check("late_done_start", {31'd0, chk_start}, 32'd0);
                exp_q.delete();
                exp_p.delete();
                return;
            end
            lat = (lat_in < 0) ? int'($urandom_range(0, 3)) : lat_in;
            repeat (lat) begin
                check("wait_gnt", {30'd0, gnt}, (p == 1) ? 32'd2 : 32'd1);
                check("wait_div", {24'd0, chk_div}, {24'd0, e});
                step();
            end
            chk_done = 1'b1;
            chk_ok   = is_factor(e);
            ok_m[p]  = chk_ok;
            chk_m[p] = 1'b1;
            step();
            chk_done = 1'b0;
            chk_ok   = 1'b0;
            check("wrong_rise", {31'd0, wrong[p]}, {31'd0, !ok_m[p]});
        end
        check("judg", {30'd0, judg}, {30'd0, ok_m});
        check("busy_after", {31'd0, busy}, {31'd0, ok_m != 2'b00});
        check("wrong_after", {30'd0, wrong & chk_m}, {30'd0, chk_m & ~ok_m});
        if (ok_m != 2'b00) begin
            req = 2'b11;
            step();
            req = 2'b00;
            repeat (3) begin
                check("done_start", {31'd0, chk_start}, 32'd0);
                check("done_busy", {31'd0, busy}, 32'd1);
                check("done_judg", {30'd0, judg}, {30'd0, ok_m});
                check("done_gnt", {30'd0, gnt}, 32'd0);
                step();
            end
            mark_abort();
            en = 1'b0;
            step();
            en = 1'b1;
            check("clr_busy", {31'd0, busy}, 32'd0);
            check("clr_judg", {30'd0, judg}, 32'd0);
            check("clr_wrong", {30'd0, wrong}, 32'd0);
        end else begin
            p   = wrong[0] ? 0 : 1;
            req = (p == 0) ? 2'b01 : 2'b10;
            step();
            req = 2'b00;
            repeat (4) begin
                check("locked_req_start", {31'd0, chk_start}, 32'd0);
                check("locked_req_busy", {31'd0, busy}, 32'd0);
                step();
            end
        end
    endtask

    // Lockout length monitor: every uninterrupted WRONG pulse lasts LOCK cycles.
    initial begin : lock_mon
        int cnt[2];
        int abort_seen[2];
        cnt        = '{0, 0};
        abort_seen = '{0, 0};
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (wrong[p]) begin
                    cnt[p]++;
                end else if (cnt[p] != 0) begin
                    if (abort_seen[p] != abort_req[p]) begin
                        abort_seen[p] = abort_req[p];
                    end else begin
                        check("lock_len", 32'(cnt[p]), 32'(LOCK));
                    end
                    cnt[p] = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        abort_req = '{0, 0};
        #12;
        check("rst_start", {31'd0, chk_start}, 32'd0);
        check("rst_div", {24'd0, chk_div}, 32'd0);
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_judg", {30'd0, judg}, 32'd0);
        check("rst_wrong", {30'd0, wrong}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        step();
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (4) step();

        // Directed cases.
        do_round(2'b01, 8'd7, 8'd0, 2, 1'b0);
        do_round(2'b11, 8'd6, 8'd14, -1, 1'b0);
        do_round(2'b10, 8'd0, 8'd4, -1, 1'b0);
        do_round(2'b11, 8'd5, 8'd21, -1, 1'b0);
        do_round(2'b01, 8'd3, 8'd0, -1, 1'b1);

        // Asynchronous reset in the middle of a check.
        wait_quiet();
        ans0 = 8'd9;
        req  = 2'b01;
        step();
        req = 2'b00;
        step();
        step();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_gnt", {30'd0, gnt}, 32'd1);
        mark_abort();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_start", {31'd0, chk_start}, 32'd0);
        check("arst_div", {24'd0, chk_div}, 32'd0);
        check("arst_gnt", {30'd0, gnt}, 32'd0);
        check("arst_judg", {30'd0, judg}, 32'd0);
        check("arst_wrong", {30'd0, wrong}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        rst_n    = 1'b1;
        rr_m     = 1'b0;
        chk_done = 1'b1;
        chk_ok   = 1'b1;
        step();
        chk_done = 1'b0;
        chk_ok   = 1'b0;
        repeat (6) begin
            check("post_rst_start", {31'd0, chk_start}, 32'd0);
            check("post_rst_busy", {31'd0, busy}, 32'd0);
            step();
        end

        // After reset the pair pointer is back at player 0.
        do_round(2'b11, 8'd2, 8'd3, -1, 1'b0);

        // Randomized rounds.
        for (int i = 0; i < 40; i++) begin
            do_round(2'($urandom_range(1, 3)), pick_ans(), pick_ans(), -1,
                     ($urandom_range(0, 7) == 0));
        end

        wait_quiet();
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/judge_arbiter.md
JUDGE_ARBITER -- requirements
Module: judge_arbiter

Interface
REQ-001 Parameter LOCK_CYC, default 50_000_000, lockout length in CLK cycles after a wrong answer (1 s at 50 MHz).
REQ-002 Parameter W_ANS, default 8, answer/divisor width.
REQ-003 CLK  in  1  single system clock, rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 EN  in  1  game is in answer phase; low aborts and clears.
REQ-006 REQ  in  2  per-player submit pulse (bit0 = player0, bit1 = player1).
REQ-007 ANS0, ANS1  in  W_ANS  candidate factor per player; sampled with REQ.
REQ-008 CHK_DONE  in  1  one-cycle pulse from shared factor checker.
REQ-009 CHK_OK  in  1  checker verdict, valid with CHK_DONE (divides question, nontrivial).
REQ-010 CHK_START  out  1  one-cycle pulse launching a check.
REQ-011 CHK_DIV  out  W_ANS  divisor to checker; stable from CHK_START until CHK_DONE.
REQ-012 GNT  out  2  one-hot owner of the checker; 00 when idle.
REQ-013 JUDG  out  2  result: 01 player0 correct, 10 player1 correct, 11 draw, 00 none.
REQ-014 WRONG  out  2  bit p high while player p is locked out.
REQ-015 BUSY  out  1  high in any state other than IDLE.

Function
REQ-016 REQ[p] sets pend[p] and latches ANSp only if EN=1, WRONG[p]=0, pend[p]=0, and state is not DONE; otherwise ignored.
REQ-017 States: IDLE, ISSUE, WAIT, DONE, all registered.
REQ-018 IDLE: one pend set -> cur = that player, pair=0; both set in the same cycle (or both set by the time IDLE evaluates) -> cur = rr pointer, pair=1, rr toggles; go ISSUE.
REQ-019 ISSUE: CHK_START=1 for exactly one cycle, CHK_DIV=latched answer of cur, GNT[cur]=1; go WAIT.
REQ-020 WAIT: hold GNT and CHK_DIV; on CHK_DONE, clear pend[cur] and record ok[cur]=CHK_OK.
REQ-021 On CHK_DONE with CHK_OK=0: WRONG[cur] rises next cycle and the lockout counter loads LOCK_CYC-1.
REQ-022 On CHK_DONE with pair=1 and the other player unchecked: cur = other, go ISSUE.
REQ-023 On final CHK_DONE: any ok set -> JUDG={ok1,ok0}, go DONE; none -> JUDG=00, go IDLE.
REQ-024 DONE: hold JUDG; new REQ ignored; EN low -> IDLE.
REQ-025 Lockout counter per player decrements each cycle; WRONG[p] falls in the cycle after the counter reaches 0; both counters run independently.
REQ-026 EN low in any state: next cycle state=IDLE, pend, ok, JUDG, GNT, lockouts cleared; a CHK_DONE arriving while IDLE is ignored.
REQ-027 Latency: single REQ -> CHK_START 2 cycles later; CHK_DONE -> JUDG valid 1 cycle later.
REQ-028 REQ[p] coincident with the final CHK_DONE that enters DONE is discarded.

Reset
REQ-029 RST_N low: state=IDLE, rr=player0, pend=00, ok=00, counters=0; outputs CHK_START=0, CHK_DIV=0, GNT=00, JUDG=00, WRONG=00, BUSY=0.
REQ-030 Reset takes effect immediately; release is synchronised to CLK before the FSM leaves IDLE.

Structure
REQ-031 State encodings, JUDG codes (NONE/P0/P1/DRAW) and the default LOCK_CYC belong in the shared game package, alongside the main game-controller state codes.
REQ-032 One sub-module, lockout_timer (load, count, busy flag), instantiated once per player.

Verification
REQ-033 EN=1, REQ=01, ANS0=7, checker OK=1 after 3 cycles -> CHK_START 2 cycles after REQ, CHK_DIV=7, GNT=01, JUDG=01, BUSY stays high in DONE.
REQ-034 REQ=11 same cycle, rr=p0, both OK -> two checks in order p0 then p1, JUDG=11, rr=p1 afterwards.
REQ-035 REQ=10, ANS1=4, OK=0 (LOCK_CYC=10 in bench) -> WRONG=10 for exactly 10 cycles, a REQ[1] during lockout is ignored, JUDG=00.
REQ-036 REQ=11, p0 wrong, p1 correct -> WRONG=01, JUDG=10.
REQ-037 EN drops while in WAIT -> IDLE next cycle, GNT=00, the late CHK_DONE is ignored, JUDG=00.
REQ-038 RST_N asserted mid-WAIT -> all outputs take reset values asynchronously, with no CHK_START after release until a new REQ.
